// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/instruction cache and the decoder.
// Optional macro FETCHQ_BYPASS_EN adds a zero-latency path from cache to decoder when the queue is empty.
module fetch_queue #(
    parameter int DEPTH      = 8,
    parameter int PEND_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_stall,
    input  logic              cache_inst_enable,
    input  logic [INST_W-1:0] cache_inst,
    input  logic              clear,
    input  logic              dec_stall,
    output logic              dec_enable,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [INST_W-1:0] dec_inst
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PP_W   = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int PCNT_W = PP_W + 1;
    localparam int SUM_W  = ((CNT_W > PCNT_W) ? CNT_W : PCNT_W) + 1;

    localparam logic [SUM_W-1:0]  CREDIT_LIMIT = SUM_W'(DEPTH);
    localparam logic [PCNT_W-1:0] PEND_FULL    = PCNT_W'(PEND_DEPTH);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PP_W-1:0]     pend_wr_ptr_q, pend_wr_ptr_d;
    logic [PP_W-1:0]     pend_rd_ptr_q, pend_rd_ptr_d;
    logic [PCNT_W-1:0]   pend_count_q, pend_count_d;
    logic [PCNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [ADDR_W-1:0]   pend_mem   [2**PP_W];
    logic [ADDR_W-1:0]   q_pc_mem   [DEPTH];
    logic [INST_W-1:0]   q_inst_mem [DEPTH];

    logic                running;
    logic                q_empty;
    logic                pend_empty;
    logic [SUM_W-1:0]    credit_used;
    logic                pend_push;
    logic                resp_accept;
    logic                bypass_hit;
    logic                bypass_take;
    logic                q_push;
    logic                q_pop;
    logic [PCNT_W-1:0]   outstanding;
    logic [PCNT_W-1:0]   consumed_now;

    // Handshake decode; everything here is combinational from registers plus this cycle's inputs.
    always_comb begin
        running     = (state_q == ST_RUN);
        q_empty     = (count_q == '0);
        pend_empty  = (pend_count_q == '0);
        credit_used = SUM_W'(count_q) + SUM_W'(pend_count_q);

        pc_stall    = (credit_used >= CREDIT_LIMIT) || (pend_count_q == PEND_FULL)
                      || !running || clear;
        pend_push   = pc_valid && !pc_stall;
        resp_accept = running && !clear && cache_inst_enable && !pend_empty;

`ifdef FETCHQ_BYPASS_EN
        bypass_hit  = resp_accept && q_empty;
`else
        bypass_hit  = 1'b0;
`endif
        bypass_take = bypass_hit && !dec_stall;
        q_push      = resp_accept && !bypass_take;
        q_pop       = !q_empty && running && !dec_stall && !clear;
    end

    // Outputs are forced to zero when nothing is valid, so the unreset storage never leaks out.
    always_comb begin
        dec_enable = (!q_empty && running) || bypass_hit;
        dec_pc     = '0;
        dec_inst   = '0;
        if (bypass_hit) begin
            dec_pc   = pend_mem[pend_rd_ptr_q];
            dec_inst = cache_inst;
        end else if (dec_enable) begin
            dec_pc   = q_pc_mem[rd_ptr_q];
            dec_inst = q_inst_mem[rd_ptr_q];
        end
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through this block can infer a latch.
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pend_wr_ptr_d = pend_wr_ptr_q;
        pend_rd_ptr_d = pend_rd_ptr_q;
        pend_count_d  = pend_count_q;
        drop_cnt_d    = drop_cnt_q;

        // Responses still in flight: tracked by pending in RUN, by drop_cnt in DRAIN.
        outstanding   = running ? pend_count_q : drop_cnt_q;
        consumed_now  = (cache_inst_enable && (outstanding != '0)) ? PCNT_W'(1) : '0;

        if (clear) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            pend_wr_ptr_d = '0;
            pend_rd_ptr_d = '0;
            pend_count_d  = '0;
            drop_cnt_d    = outstanding - consumed_now;
            state_d       = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (pend_push) pend_wr_ptr_d = pend_wr_ptr_q + PP_W'(1);
            if (resp_accept) pend_rd_ptr_d = pend_rd_ptr_q + PP_W'(1);
            case ({pend_push, resp_accept})
                2'b10:   pend_count_d = pend_count_q + PCNT_W'(1);
                2'b01:   pend_count_d = pend_count_q - PCNT_W'(1);
                default: pend_count_d = pend_count_q;
            endcase

            if (q_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (q_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({q_push, q_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if (!running && cache_inst_enable && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - PCNT_W'(1);
                if (drop_cnt_q == PCNT_W'(1)) state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= ST_RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pend_wr_ptr_q <= '0;
            pend_rd_ptr_q <= '0;
            pend_count_q  <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pend_wr_ptr_q <= pend_wr_ptr_d;
            pend_rd_ptr_q <= pend_rd_ptr_d;
            pend_count_q  <= pend_count_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // NOTE: storage arrays are not reset; the counters define validity, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (pend_push) pend_mem[pend_wr_ptr_q] <= pc_in;
        if (q_push) begin
            q_pc_mem[wr_ptr_q]   <= pend_mem[pend_rd_ptr_q];
            q_inst_mem[wr_ptr_q] <= cache_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Table-driven bench for fetch_queue: one record per clock cycle, outputs compared on the falling edge.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_stall;
    logic        cache_inst_enable;
    logic [31:0] cache_inst;
    logic        clear;
    logic        dec_stall;
    logic        dec_enable;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH(8),
        .PEND_DEPTH(4),
        .ADDR_W(32),
        .INST_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_in(pc_in),
        .pc_valid(pc_valid),
        .pc_stall(pc_stall),
        .cache_inst_enable(cache_inst_enable),
        .cache_inst(cache_inst),
        .clear(clear),
        .dec_stall(dec_stall),
        .dec_enable(dec_enable),
        .dec_pc(dec_pc),
        .dec_inst(dec_inst)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [31:0] pc;
        logic        ce;
        logic [31:0] inst;
        logic        clr;
        logic        ds;
        logic        e_stall;
        logic        e_en;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r, input int pv, input int pc, input int ce,
                                input int inst, input int clr, input int ds,
                                input int es, input int ee, input int epc, input int einst);
        vec_t v;
        v.rst     = (r != 0);
        v.pv      = (pv != 0);
        v.pc      = pc;
        v.ce      = (ce != 0);
        v.inst    = inst;
        v.clr     = (clr != 0);
        v.ds      = (ds != 0);
        v.e_stall = (es != 0);
        v.e_en    = (ee != 0);
        v.e_pc    = epc;
        v.e_inst  = einst;
        return v;
    endfunction

    function automatic int a_inst(input int i);
        return 32'hA000_0000 + i;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        rst               = v.rst;
        pc_valid          = v.pv;
        pc_in             = v.pc;
        cache_inst_enable = v.ce;
        cache_inst        = v.inst;
        clear             = v.clr;
        dec_stall         = v.ds;
        @(negedge clk);
        check($sformatf("v%0d pc_stall", idx), 64'(pc_stall), 64'(v.e_stall));
        check($sformatf("v%0d dec_enable", idx), 64'(dec_enable), 64'(v.e_en));
        check($sformatf("v%0d dec_pc", idx), 64'(dec_pc), 64'(v.e_pc));
        check($sformatf("v%0d dec_inst", idx), 64'(dec_inst), 64'(v.e_inst));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst               = 1'b0;
        pc_valid          = 1'b0;
        pc_in             = '0;
        cache_inst_enable = 1'b0;
        cache_inst        = '0;
        clear             = 1'b0;
        dec_stall         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lat;
        bit  found;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset pc_stall", 64'(pc_stall), 64'(0));
        check("reset dec_enable", 64'(dec_enable), 64'(0));
        check("reset dec_pc", 64'(dec_pc), 64'(0));
        check("reset dec_inst", 64'(dec_inst), 64'(0));
        @(posedge clk);
        #1;

`ifdef FETCHQ_BYPASS_EN
        // Zero-latency path, then the same path with the decoder stalled.
        vecs.push_back(mk(0, 1, 'h40, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h00500293, 0, 0,  0, 1, 'h40, 'h00500293));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h44, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h00600313, 0, 1,  0, 1, 'h44, 'h00600313));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 'h44, 'h00600313));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
`else
        // Three back-to-back fetches, one cycle response latency each.
        vecs.push_back(mk(0, 1, 'h0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h4, 1, 'h00000013, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h8, 1, 'h00100093, 0, 0,  0, 1, 'h0, 'h00000013));
        vecs.push_back(mk(0, 0, 0, 1, 'h00200113, 0, 0,  0, 1, 'h4, 'h00100093));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 'h8, 'h00200113));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Fill with the decoder stalled until the credit limit, then drain across the pointer wrap.
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 'h40 + 4 * i, (i > 0) ? 1 : 0, (i > 0) ? a_inst(i - 1) : 0, 0, 1,
                              0, (i >= 2) ? 1 : 0, (i >= 2) ? 'h40 : 0, (i >= 2) ? a_inst(0) : 0));
        vecs.push_back(mk(0, 1, 'h60, 0, 0, 0, 1,  1, 1, 'h40, a_inst(0)));
        vecs.push_back(mk(0, 0, 0, 1, a_inst(7), 0, 1,  1, 1, 'h40, a_inst(0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 'h40, a_inst(0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 1, 'h40, a_inst(0)));
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 'h40 + 4 * i, a_inst(i)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Flush with three outstanding requests; three stale responses are dropped.
        vecs.push_back(mk(0, 1, 'h20, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h24, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h28, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h2C, 0, 0, 1, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hDEAD0001, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hDEAD0002, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hDEAD0003, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h100, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h00300193, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 'h100, 'h00300193));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Flush coincident with a response, two pending: only one more response is dropped.
        vecs.push_back(mk(0, 1, 'h200, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h204, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hBEEF0000, 1, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hBEEF0001, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h300, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'h12345678, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 'h300, 'h12345678));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));

        // Reset while draining; later stale responses must be ignored.
        vecs.push_back(mk(0, 1, 'h400, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h404, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hCAFE0000, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 'hCAFE0001, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
`endif

        foreach (vecs[i]) apply(vecs[i], i);

`ifndef FETCHQ_BYPASS_EN
        // Bounded wait for the registered response path: must appear exactly one edge after the response.
        idle_inputs();
        pc_valid = 1'b1;
        pc_in    = 32'h500;
        @(posedge clk);
        #1;
        pc_valid          = 1'b0;
        cache_inst_enable = 1'b1;
        cache_inst        = 32'h0BADF00D;
        @(negedge clk);
        check("latency before edge dec_enable", 64'(dec_enable), 64'(0));
        @(posedge clk);
        #1;
        cache_inst_enable = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (dec_enable) found = 1'b1;
            else begin
                lat++;
                @(posedge clk);
                #1;
            end
        end
        check("latency dec_enable seen", 64'(found), 64'(1));
        check("latency cycles", 64'(lat), 64'(0));
        check("latency dec_pc", 64'(dec_pc), 64'(32'h500));
        check("latency dec_inst", 64'(dec_inst), 64'(32'h0BADF00D));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("latency popped dec_enable", 64'(dec_enable), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
